// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB master bridge.
// Optional ACCESS timeout is enabled with the APB_TIMEOUT_EN macro.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  localparam int DEF_ADDR_WIDTH  = 3;
  localparam int DEF_SEL_WIDTH   = 2;
  localparam int DEF_WRITE_WIDTH = 32;
  localparam int MAX_SEL_WIDTH   = 64;

  function automatic int strb_width(
    input int w
  );
    return (w + 7) / 8;
  endfunction

  function automatic int idx_width(
    input int n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Callers truncate the result to their own sel width.
  function automatic logic [MAX_SEL_WIDTH-1:0] sel_onehot(
    input int idx
  );
    logic [MAX_SEL_WIDTH-1:0] one;
    one = {{(MAX_SEL_WIDTH-1){1'b0}}, 1'b1};
    if (idx < 0 || idx >= MAX_SEL_WIDTH) begin
      return '0;
    end
    return one << idx;
  endfunction

  localparam int DEF_IDX_W  = idx_width(DEF_SEL_WIDTH);
  localparam int DEF_STRB_W = strb_width(DEF_WRITE_WIDTH);

  typedef struct packed {
    logic                       write;
    logic [DEF_ADDR_WIDTH-1:0]  addr;
    logic [DEF_IDX_W-1:0]       sel_idx;
    logic [2:0]                 prot;
    logic [DEF_WRITE_WIDTH-1:0] wdata;
    logic [DEF_STRB_W-1:0]      strb;
  } req_t;

endpackage

// File: rtl/apb_master_bridge.sv
// Valid/ready request to single APB transfer bridge, registered outputs.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 3,
  parameter int SEL_WIDTH      = 2,
  parameter int WRITE_WIDTH    = 32,
  parameter int READ_WIDTH     = WRITE_WIDTH,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int SEL_IDX_W     = idx_width(SEL_WIDTH),
  localparam int STRB_WIDTH    = strb_width(WRITE_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [SEL_IDX_W-1:0]   req_sel_idx,
  input  logic [2:0]             req_prot,
  input  logic [WRITE_WIDTH-1:0] req_wdata,
  input  logic [STRB_WIDTH-1:0]  req_strb,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [READ_WIDTH-1:0]  rsp_rdata,
  output logic                   rsp_err,
  output logic [ADDR_WIDTH-1:0]  apb_addr,
  output logic [2:0]             apb_prot,
  output logic [SEL_WIDTH-1:0]   apb_sel,
  output logic                   apb_enable,
  output logic                   apb_write,
  output logic [WRITE_WIDTH-1:0] apb_wdata,
  output logic [STRB_WIDTH-1:0]  apb_strb,
  input  logic                   apb_ready,
  input  logic [READ_WIDTH-1:0]  apb_rdata,
  input  logic                   apb_slv_err
);

`ifdef APB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t state;
  state_t next_state;

  logic accept;
  logic idx_ok;
  logic to_hit;

  logic [CNT_W-1:0] to_cnt;

  logic                   req_ready_d;
  logic                   rsp_valid_d;
  logic [READ_WIDTH-1:0]  rsp_rdata_d;
  logic                   rsp_err_d;
  logic [ADDR_WIDTH-1:0]  apb_addr_d;
  logic [2:0]             apb_prot_d;
  logic [SEL_WIDTH-1:0]   apb_sel_d;
  logic                   apb_enable_d;
  logic                   apb_write_d;
  logic [WRITE_WIDTH-1:0] apb_wdata_d;
  logic [STRB_WIDTH-1:0]  apb_strb_d;

  assign accept = (state == IDLE)
                & req_valid
                & req_ready;

  assign idx_ok = int'(req_sel_idx) < SEL_WIDTH;

  // Counter reaches the limit after TIMEOUT_CYCLES low-ready cycles.
  assign to_hit = TIMEOUT_EN
                & ~apb_ready
                & (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      apb_addr   <= '0;
      apb_prot   <= '0;
      apb_sel    <= '0;
      apb_enable <= 1'b0;
      apb_write  <= 1'b0;
      apb_wdata  <= '0;
      apb_strb   <= '0;
    end else begin
      state      <= next_state;
      req_ready  <= req_ready_d;
      rsp_valid  <= rsp_valid_d;
      rsp_rdata  <= rsp_rdata_d;
      rsp_err    <= rsp_err_d;
      apb_addr   <= apb_addr_d;
      apb_prot   <= apb_prot_d;
      apb_sel    <= apb_sel_d;
      apb_enable <= apb_enable_d;
      apb_write  <= apb_write_d;
      apb_wdata  <= apb_wdata_d;
      apb_strb   <= apb_strb_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (accept) begin
      to_cnt <= '0;
    end else if (state == ACCESS && !apb_ready) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          next_state = idx_ok ? SETUP : RESP;
        end
      end
      SETUP: begin
        next_state = ACCESS;
      end
      ACCESS: begin
        if (apb_ready || to_hit) begin
          next_state = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready_d  = (next_state == IDLE);
    rsp_valid_d  = (next_state == RESP);
    rsp_rdata_d  = rsp_rdata;
    rsp_err_d    = rsp_err;
    apb_addr_d   = apb_addr;
    apb_prot_d   = apb_prot;
    apb_sel_d    = apb_sel;
    apb_enable_d = apb_enable;
    apb_write_d  = apb_write;
    apb_wdata_d  = apb_wdata;
    apb_strb_d   = apb_strb;
    unique case (state)
      IDLE: begin
        if (accept && idx_ok) begin
          apb_addr_d  = req_addr;
          apb_prot_d  = req_prot;
          apb_write_d = req_write;
          apb_wdata_d = req_wdata;
          apb_strb_d  = req_write ? req_strb : '0;
          apb_sel_d   = SEL_WIDTH'(
            sel_onehot(int'(req_sel_idx)));
        end else if (accept) begin
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      SETUP: begin
        apb_enable_d = 1'b1;
      end
      ACCESS: begin
        if (apb_ready) begin
          apb_sel_d    = '0;
          apb_enable_d = 1'b0;
          rsp_err_d    = apb_slv_err;
          rsp_rdata_d  = apb_write ? '0 : apb_rdata;
        end else if (to_hit) begin
          apb_sel_d    = '0;
          apb_enable_d = 1'b0;
          rsp_err_d    = 1'b1;
          rsp_rdata_d  = '0;
        end
      end
      RESP: begin
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomised self-checking bench for apb_master_bridge.
// Covers APB_TIMEOUT_EN when the macro is defined for the build.
module tb_apb_master_bridge;

  localparam int AW  = 3;
  localparam int SW  = 3;
  localparam int IW  = 2;
  localparam int WW  = 32;
  localparam int SBW = 4;
  localparam int TO  = 4;

`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk;
  logic           reset;
  logic           req_valid;
  logic           req_ready;
  logic           req_write;
  logic [AW-1:0]  req_addr;
  logic [IW-1:0]  req_sel_idx;
  logic [2:0]     req_prot;
  logic [WW-1:0]  req_wdata;
  logic [SBW-1:0] req_strb;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [WW-1:0]  rsp_rdata;
  logic           rsp_err;
  logic [AW-1:0]  apb_addr;
  logic [2:0]     apb_prot;
  logic [SW-1:0]  apb_sel;
  logic           apb_enable;
  logic           apb_write;
  logic [WW-1:0]  apb_wdata;
  logic [SBW-1:0] apb_strb;
  logic           apb_ready;
  logic [WW-1:0]  apb_rdata;
  logic           apb_slv_err;

  int errors = 0;
  int checks = 0;

  apb_master_bridge #(
    .ADDR_WIDTH(AW),
    .SEL_WIDTH(SW),
    .WRITE_WIDTH(WW),
    .READ_WIDTH(WW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_sel_idx(req_sel_idx),
    .req_prot(req_prot),
    .req_wdata(req_wdata),
    .req_strb(req_strb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .apb_addr(apb_addr),
    .apb_prot(apb_prot),
    .apb_sel(apb_sel),
    .apb_enable(apb_enable),
    .apb_write(apb_write),
    .apb_wdata(apb_wdata),
    .apb_strb(apb_strb),
    .apb_ready(apb_ready),
    .apb_rdata(apb_rdata),
    .apb_slv_err(apb_slv_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: the response and bus timing follow from the transfer alone.
  task automatic do_xfer(
    input string          name,
    input bit             wr,
    input logic [AW-1:0]  addr,
    input logic [IW-1:0]  idx,
    input logic [2:0]     prot,
    input logic [WW-1:0]  wdata,
    input logic [SBW-1:0] strb,
    input logic [WW-1:0]  rdata,
    input bit             serr,
    input int             waits,
    input int             bp
  );
    bit             ok_idx;
    bit             tmo;
    int             n;
    int             k;
    logic [SW-1:0]  exp_sel;
    logic [SBW-1:0] exp_strb;
    logic [WW-1:0]  exp_rd;
    bit             exp_err;
    ok_idx   = int'(idx) < SW;
    tmo      = TO_EN && ok_idx && waits >= TO;
    exp_sel  = '0;
    if (ok_idx) exp_sel[idx] = 1'b1;
    exp_strb = wr ? strb : '0;
    exp_rd   = (wr || !ok_idx || tmo) ? '0 : rdata;
    exp_err  = serr || !ok_idx || tmo;
    n        = tmo ? TO : waits + 1;
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: req_ready=%b required 1",
               name, req_ready);
      return;
    end
    req_valid   = 1'b1;
    req_write   = wr;
    req_addr    = addr;
    req_sel_idx = idx;
    req_prot    = prot;
    req_wdata   = wdata;
    req_strb    = strb;
    step();
    req_valid   = 1'b0;
    req_write   = 1'($urandom);
    req_addr    = AW'($urandom);
    req_sel_idx = IW'($urandom);
    req_prot    = 3'($urandom);
    req_wdata   = $urandom;
    req_strb    = SBW'($urandom);
    if (ok_idx) begin
      checks++;
      if ({apb_sel, apb_enable, apb_addr, apb_prot,
           apb_write, apb_wdata, apb_strb,
           req_ready, rsp_valid}
          !== {exp_sel, 1'b0, addr, prot,
               wr, wdata, exp_strb, 2'b00}) begin
        errors++;
        $display("FAIL %s setup: sel=%b en=%b a=%h p=%h w=%b d=%h s=%h rr=%b rv=%b required sel=%b en=0 a=%h p=%h w=%b d=%h s=%h rr=0 rv=0",
                 name, apb_sel, apb_enable, apb_addr, apb_prot,
                 apb_write, apb_wdata, apb_strb, req_ready,
                 rsp_valid, exp_sel, addr, prot, wr, wdata,
                 exp_strb);
      end
      apb_ready   = 1'($urandom);
      apb_slv_err = 1'($urandom);
      apb_rdata   = $urandom;
      for (int i = 0; i < n; i++) begin
        step();
        checks++;
        if ({apb_sel, apb_enable, apb_addr, apb_prot,
             apb_write, apb_wdata, apb_strb,
             req_ready, rsp_valid}
            !== {exp_sel, 1'b1, addr, prot,
                 wr, wdata, exp_strb, 2'b00}) begin
          errors++;
          $display("FAIL %s access%0d: sel=%b en=%b a=%h w=%b d=%h s=%h rr=%b rv=%b required sel=%b en=1 a=%h w=%b d=%h s=%h rr=0 rv=0",
                   name, i, apb_sel, apb_enable, apb_addr,
                   apb_write, apb_wdata, apb_strb, req_ready,
                   rsp_valid, exp_sel, addr, wr, wdata, exp_strb);
        end
        apb_ready   = (i == waits);
        apb_rdata   = (i == waits) ? rdata : $urandom;
        apb_slv_err = (i == waits) ? serr : 1'($urandom);
        rsp_ready   = 1'($urandom);
      end
      step();
    end
    apb_ready = 1'b0;
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, rsp_rdata, rsp_err,
         apb_sel, apb_enable, req_ready}
        !== {1'b1, exp_rd, exp_err,
             SW'(0), 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s resp: rv=%b rd=%h err=%b sel=%b en=%b rr=%b required rv=1 rd=%h err=%b sel=0 en=0 rr=0",
               name, rsp_valid, rsp_rdata, rsp_err, apb_sel,
               apb_enable, req_ready, exp_rd, exp_err);
    end
    for (int j = 0; j < bp; j++) begin
      req_valid   = 1'($urandom);
      req_sel_idx = IW'($urandom);
      step();
      checks++;
      if ({rsp_valid, rsp_rdata, rsp_err, req_ready, apb_sel}
          !== {1'b1, exp_rd, exp_err, 1'b0, SW'(0)}) begin
        errors++;
        $display("FAIL %s hold%0d: rv=%b rd=%h err=%b rr=%b sel=%b required rv=1 rd=%h err=%b rr=0 sel=0",
                 name, j, rsp_valid, rsp_rdata, rsp_err,
                 req_ready, apb_sel, exp_rd, exp_err);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, req_ready, apb_sel} !== {2'b01, SW'(0)}) begin
      errors++;
      $display("FAIL %s release: rv=%b rr=%b sel=%b required rv=0 rr=1 sel=0",
               name, rsp_valid, req_ready, apb_sel);
    end
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_sel_idx = '0;
    req_prot    = '0;
    req_wdata   = '0;
    req_strb    = '0;
    rsp_ready   = 1'b0;
    apb_ready   = 1'b0;
    apb_rdata   = '0;
    apb_slv_err = 1'b0;
    step();
    step();
    checks++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err, apb_addr,
         apb_prot, apb_sel, apb_enable, apb_write, apb_wdata,
         apb_strb} !== '0) begin
      errors++;
      $display("FAIL reset outputs: rr=%b rv=%b rd=%h err=%b a=%h sel=%b en=%b d=%h s=%h required all 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err,
               apb_addr, apb_sel, apb_enable, apb_wdata, apb_strb);
    end
    reset = 1'b0;
    step();
    checks++;
    if ({req_ready, rsp_valid, apb_sel, apb_enable}
        !== {2'b10, SW'(0), 1'b0}) begin
      errors++;
      $display("FAIL reset idle: rr=%b rv=%b sel=%b en=%b required rr=1 rv=0 sel=0 en=0",
               req_ready, rsp_valid, apb_sel, apb_enable);
    end
  endtask

  task automatic test_write_zero_wait();
    do_xfer("write0", 1'b1, 3'h5, 2'd1, 3'($urandom),
            32'hDEADBEEF, 4'hF, $urandom, 1'b0, 0, 0);
  endtask

  task automatic test_read_wait();
    do_xfer("read2", 1'b0, 3'h2, 2'd2, 3'($urandom),
            $urandom, 4'hF, 32'h12345678, 1'b0, 2, 0);
  endtask

  task automatic test_slave_error();
    do_xfer("slverr", 1'b1, 3'h7, 2'd0, 3'h3,
            $urandom, 4'h5, $urandom, 1'b1, 1, 4);
  endtask

  task automatic test_backpressure();
    do_xfer("bp", 1'b0, 3'h1, 2'd1, 3'h0,
            $urandom, 4'h0, $urandom, 1'b0, 0, 10);
  endtask

  task automatic test_bad_index();
    do_xfer("badidx", 1'b0, 3'h4, 2'd3, 3'h1,
            $urandom, 4'hF, $urandom, 1'b0, 0, 2);
  endtask

  task automatic test_long_wait();
    do_xfer("longwait", 1'b0, 3'h6, 2'd2, 3'h2,
            $urandom, 4'hF, $urandom, 1'b0, TO + 2, 1);
  endtask

  task automatic test_reset_mid_access();
    int k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    req_valid   = 1'b1;
    req_write   = 1'b0;
    req_addr    = 3'h3;
    req_sel_idx = 2'd2;
    step();
    req_valid = 1'b0;
    apb_ready = 1'b0;
    step();
    checks++;
    if (apb_enable !== 1'b1) begin
      errors++;
      $display("FAIL midrst pre: en=%b required 1", apb_enable);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({apb_sel, apb_enable, rsp_valid, req_ready,
         apb_addr, apb_strb, rsp_err} !== '0) begin
      errors++;
      $display("FAIL midrst async: sel=%b en=%b rv=%b rr=%b a=%h required all 0",
               apb_sel, apb_enable, rsp_valid, req_ready, apb_addr);
    end
    step();
    reset = 1'b0;
    step();
    checks++;
    if ({req_ready, rsp_valid, apb_sel, apb_enable}
        !== {2'b10, SW'(0), 1'b0}) begin
      errors++;
      $display("FAIL midrst idle: rr=%b rv=%b sel=%b en=%b required rr=1 rv=0 sel=0 en=0",
               req_ready, rsp_valid, apb_sel, apb_enable);
    end
    do_xfer("afterrst", 1'b1, 3'h0, 2'd0, 3'h7,
            $urandom, 4'hA, $urandom, 1'b0, 1, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      do_xfer("rand", 1'($urandom), AW'($urandom),
              IW'($urandom_range(0, 3)), 3'($urandom),
              $urandom, SBW'($urandom), $urandom,
              1'($urandom), $urandom_range(0, 3),
              $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slave_error();
    test_backpressure();
    test_bad_index();
    test_long_wait();
    test_reset_mid_access();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts a simple valid/ready request channel into single APB transfers and returns the result on a buffered valid/ready response channel.
- Sits directly upstream of the APB bus interface and drives its master signals: addr, prot, sel, enable, write, wdata, strb.
- Consumes the bus return signals ready, rdata and slv_err.
- Handles one outstanding transfer at a time.

Parameters:
- ADDR_WIDTH, 3: APB address width.
- SEL_WIDTH, 2: number of slaves; width of the one-hot sel bus.
- WRITE_WIDTH, 32: wdata width.
- READ_WIDTH, WRITE_WIDTH: rdata width.
- TIMEOUT_CYCLES, 16: ACCESS-phase wait limit. Used only with APB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  bridge accepts a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  target address.
- req_sel_idx  in  SEL_IDX_W  slave index; SEL_IDX_W = max(1, $clog2(SEL_WIDTH)).
- req_prot  in  3  protection attributes.
- req_wdata  in  WRITE_WIDTH  write data.
- req_strb  in  STRB_WIDTH  byte strobes; STRB_WIDTH = ceil(WRITE_WIDTH/8).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  READ_WIDTH  read data; 0 for writes.
- rsp_err  out  1  slave error (or timeout, see Optional Feature).
- apb_addr, apb_prot, apb_sel, apb_enable, apb_write, apb_wdata, apb_strb  out  APB master signals. Widths match the bus: ADDR_WIDTH, 3, SEL_WIDTH, 1, 1, WRITE_WIDTH, STRB_WIDTH.
- apb_ready, apb_rdata, apb_slv_err  in  APB return signals. Widths: 1, READ_WIDTH, 1.

Behaviour:
- All outputs are registered.
- On reset, every output is 0 and the state is IDLE. This applies immediately, including mid-transfer; an in-flight transfer is dropped with no response.
- FSM states are IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1, apb_sel=0, apb_enable=0.
  - apb_addr/prot/write/wdata/strb hold their last values.
  - On req_valid, latch the request and go to SETUP.
- SETUP (exactly 1 cycle):
  - apb_sel = one-hot of req_sel_idx; apb_enable=0.
  - Address, control and data are driven from the latch.
  - apb_strb = latched strb for writes, all-zero for reads.
  - Next state: ACCESS.
- ACCESS:
  - apb_enable=1; all other bus signals are held stable.
  - While apb_ready=0, stay in ACCESS.
  - When apb_ready=1, capture apb_slv_err into rsp_err, and apb_rdata into rsp_rdata for reads (0 for writes).
  - Drop apb_sel and apb_enable, then go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable.
  - On rsp_ready, clear rsp_valid and go to IDLE.
- req_ready is 0 in every state except IDLE.
- req_sel_idx >= SEL_WIDTH: no APB transfer. Go directly from IDLE to RESP with rsp_err=1 and rsp_rdata=0.
- Latency:
  - Accept at edge 0, SETUP in cycle 1, ACCESS in cycle 2.
  - With zero wait states, rsp_valid rises in cycle 3.
  - Each wait state adds 1 cycle.
  - Peak throughput: 1 transfer per 4 cycles.
- Simultaneous events:
  - rsp_ready asserted before rsp_valid has no effect.
  - req_valid held during RESP is ignored until IDLE.
- apb_slv_err is sampled only in the cycle where apb_enable=1 and apb_ready=1.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- When defined, a counter counts ACCESS cycles with apb_ready=0.
  - When it reaches TIMEOUT_CYCLES, the FSM aborts: it drops apb_sel and apb_enable and goes to RESP with rsp_err=1 and rsp_rdata=0.
  - The counter clears on entry to SETUP.
- When undefined, the bridge waits indefinitely for apb_ready, and TIMEOUT_CYCLES is unused.

Decomposition:
- Package apb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, RESP);
  - a function computing STRB_WIDTH from a width;
  - a function computing the index width;
  - a request struct typedef parameterised through the package defaults.
- No sub-module is needed. The one-hot sel decode is a function in apb_pkg.

Test Plan:
- Write, zero wait: req addr=3'h5, sel_idx=1, wdata=32'hDEADBEEF, strb=4'hF. Required:
  - SETUP with sel=2'b10, enable=0;
  - ACCESS with enable=1;
  - rsp_valid in cycle 3, rsp_err=0, rsp_rdata=0.
- Read, 2 wait states: ready low for 2 ACCESS cycles, apb_rdata=32'h12345678. Required:
  - apb_strb=0 throughout;
  - rsp_valid in cycle 5 with rsp_rdata=32'h12345678.
- Slave error: write with slv_err=1 at ready. Required: rsp_err=1; next request accepted only after rsp_ready.
- Backpressure: hold rsp_ready=0 for 10 cycles. Required: rsp_valid and rsp_rdata stable, req_ready=0 throughout.
- Reset mid-ACCESS: assert reset while enable=1. Required: sel, enable and rsp_valid all 0 immediately; the FSM restarts in IDLE.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYCLES=4): ready held low. Required: bus released after 4 ACCESS cycles, rsp_err=1, rsp_rdata=0.
